// File: rtl/sseg_scan_if.sv
// Bundle between the scan controller and its neighbours: the display-update
// request from the host side and the scan/display outputs to the datapath.
interface sseg_scan_if #(
  parameter int BRIGHT_BITS = 3
);
  logic                   en;
  logic [15:0]            data_in;
  logic                   hex_dec_in;
  logic                   sign_in;
  logic                   load;
  logic [BRIGHT_BITS-1:0] brightness;

  logic [15:0]            data;
  logic                   hex_dec;
  logic                   sign;
  logic [1:0]             digit_sel;
  logic                   blank;
  logic                   frame_done;
  logic                   pending;

  modport master (
    output en, data_in, hex_dec_in, sign_in, load, brightness,
    input  data, hex_dec, sign, digit_sel, blank, frame_done, pending
  );

  modport slave (
    input  en, data_in, hex_dec_in, sign_in, load, brightness,
    output data, hex_dec, sign, digit_sel, blank, frame_done, pending
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Seven-segment refresh scanner: rotates digit_sel at a fixed slot rate,
// double-buffers the displayed value to frame boundaries and PWM-blanks for brightness.
module sseg_scan_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int BRIGHT_BITS = 3
) (
  input logic         clk,
  input logic         rst,
  sseg_scan_if.slave  bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]          prescaler;
  logic [1:0]             digit_sel;
  logic [BRIGHT_BITS-1:0] pwm_cnt;

  logic [15:0] shadow_data;
  logic        shadow_hex_dec;
  logic        shadow_sign;
  logic        pending;

  logic [15:0] data;
  logic        hex_dec;
  logic        sign;
  logic        blank;
  logic        frame_done;

  logic tick;
  logic boundary;

  assign tick     = bus.en && (prescaler == TICK_LAST);
  assign boundary = tick && (digit_sel == 2'd3);

  // Scan timing: prescaler, digit rotation and the free-running PWM counter
  // all freeze while disabled so that re-enable resumes mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      digit_sel <= 2'd0;
      pwm_cnt   <= '0;
    end else if (bus.en) begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      pwm_cnt   <= pwm_cnt + BRIGHT_BITS'(1);
      if (tick) begin
        digit_sel <= digit_sel + 2'd1;
      end
    end
  end

  // Shadow register; a load on the boundary edge wins pending back for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data    <= 16'h0000;
      shadow_hex_dec <= 1'b0;
      shadow_sign    <= 1'b0;
      pending        <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_data    <= bus.data_in;
        shadow_hex_dec <= bus.hex_dec_in;
        shadow_sign    <= bus.sign_in;
        pending        <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Active display value only changes on a frame boundary, using pre-edge shadow contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= 16'h0000;
      hex_dec <= 1'b0;
      sign    <= 1'b0;
    end else if (boundary && pending) begin
      data    <= shadow_data;
      hex_dec <= shadow_hex_dec;
      sign    <= shadow_sign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      blank      <= 1'b1;
    end else begin
      frame_done <= boundary;
      blank      <= ~bus.en | (pwm_cnt > bus.brightness);
    end
  end

  assign bus.data       = data;
  assign bus.hex_dec    = hex_dec;
  assign bus.sign       = sign;
  assign bus.digit_sel  = digit_sel;
  assign bus.blank      = blank;
  assign bus.frame_done = frame_done;
  assign bus.pending    = pending;
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Refresh/scan controller that sits directly upstream of the 4-digit seven-segment datapath. It generates the rotating digit_sel at a fixed refresh rate. It double-buffers the displayed value (data, hex_dec, sign) so that updates only take effect at a frame boundary, which prevents tearing. It also produces a PWM blank signal for brightness control, which the top level uses to force the anodes off.

Parameters:
TICK_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2; prescaler width = $clog2(TICK_DIV)
BRIGHT_BITS, 3, width of the brightness input and the PWM counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable; 0 freezes the scan and blanks the display
data_in  input  16  new display value (BCD source or raw hex)
hex_dec_in  input  1  new display mode (1 = raw hex, 0 = decimal via BCD)
sign_in  input  1  new sign flag
load  input  1  single-cycle strobe; captures data_in, hex_dec_in and sign_in into the shadow register
brightness  input  BRIGHT_BITS  on-time in PWM steps, minus 1
data  output  16  active display value
hex_dec  output  1  active mode
sign  output  1  active sign
digit_sel  output  2  current digit, 0 = rightmost
blank  output  1  1 = all anodes off
frame_done  output  1  one-cycle pulse on each frame boundary
pending  output  1  shadow holds a value not yet displayed

Behaviour:
- Reset (async, immediate): prescaler 0, digit_sel 0, pwm_cnt 0, shadow 0, data 16'h0000, hex_dec 0, sign 0, pending 0, frame_done 0, blank 1.
- Prescaler: while en=1, counts 0..TICK_DIV-1. tick = en & (prescaler == TICK_DIV-1). On tick the prescaler wraps to 0 and digit_sel increments mod 4 (3 -> 0 wraps).
- Frame boundary: boundary = tick & (digit_sel == 3).
- Load: load=1 writes data_in, hex_dec_in and sign_in into the shadow on that edge and sets pending=1. A later load before the boundary overwrites the shadow (last write wins).
- Transfer: on boundary with pending=1, shadow -> data/hex_dec/sign on the same edge that digit_sel goes 3 -> 0, and pending clears. On boundary with pending=0, outputs hold.
- Load coincident with boundary: the transfer uses the shadow contents from before this edge. The shadow takes the new value and pending stays 1. The new value is displayed at the next boundary.
- frame_done: registered; equals 1 for exactly the cycle after each boundary edge, whether or not a transfer occurred.
- PWM: pwm_cnt (BRIGHT_BITS wide) increments every clock while en=1, free-running and wrapping.
- blank: registered each clock as blank <= ~en | (pwm_cnt > brightness). Consequences:
  - brightness = all-ones: never blanks while enabled.
  - brightness = 0: lit 1 of 2^BRIGHT_BITS cycles.
  - One-cycle latency from en or brightness change to blank.
- en=0: prescaler, digit_sel and pwm_cnt hold; no ticks or boundaries; blank goes to 1 on the next edge. load still captures and sets pending. On re-enable, counting resumes from the held values.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Scan and wrap: TICK_DIV=4, en=1 after reset.
   - digit_sel holds 0,1,2,3 for 4 cycles each, then returns to 0.
   - frame_done pulses once per 16 cycles, in the cycle after 3 -> 0.
2. Deferred update: load with data_in=16'h1234, hex_dec_in=1, sign_in=1 while digit_sel=1.
   - pending=1 and data stays 16'h0000 until the 3 -> 0 edge.
   - Then data=16'h1234, hex_dec=1, sign=1, pending=0.
3. Coincident load at boundary: shadow=16'h00AA pending; load 16'h00BB on the boundary edge.
   - data=16'h00AA and pending stays 1.
   - data=16'h00BB at the next boundary.
4. Brightness, en=1 steady:
   - brightness=7: blank constantly 0.
   - brightness=1: blank=0 for 2 of every 8 cycles (pwm_cnt 0,1), 1 for the other 6.
5. Enable gating: deassert en with digit_sel=2.
   - digit_sel holds 2, blank=1 the next cycle, no frame_done.
   - A load while disabled sets pending.
   - Re-assert en: scanning resumes from 2 and the transfer occurs at the next 3 -> 0.
6. Reset mid-frame: assert rst asynchronously (between edges) with digit_sel=3, data=16'h1234, pending=1.
   - All outputs return to reset values immediately.
   - After release, scanning restarts at digit_sel=0 with blank=1 until en is asserted.
